// File: rtl/dly_fine_pkg.sv
// Shared types and default constants for the fine delay lock controller.
package dly_fine_pkg;

  localparam int unsigned DLY_N_CELL     = 16;
  localparam int unsigned DLY_SETTLE_CYC = 4;
  localparam int unsigned DLY_LOCK_CNT   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_UPDATE,
    ST_LOCKED,
    ST_ERR
  } dly_fine_state_t;

  // Two-of-three vote used by the filtered detector decision.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/dly_fine_therm.sv
// Combinational binary-to-thermometer encoder: sel[k] = 1 iff k < code.
module dly_fine_therm
  import dly_fine_pkg::*;
#(
  parameter int unsigned N_CELL = DLY_N_CELL,
  localparam int unsigned CW    = $clog2(N_CELL + 1)
) (
  input  logic [CW-1:0]     code,
  output logic [N_CELL-1:0] sel
);

  always_comb begin
    sel = '0;
    for (int unsigned k = 0; k < N_CELL; k++) begin
      sel[k] = (32'(code) > k);
    end
  end

endmodule

// File: rtl/dly_fine_ctrl.sv
// Closed-loop lock controller stepping a thermometer-coded fine delay chain.
// Optional DLY_FINE_CTRL_MAJORITY_EN: 3-sample majority vote on the detector.
module dly_fine_ctrl
  import dly_fine_pkg::*;
#(
  parameter int unsigned N_CELL     = DLY_N_CELL,
  parameter int unsigned SETTLE_CYC = DLY_SETTLE_CYC,
  parameter int unsigned LOCK_CNT   = DLY_LOCK_CNT,
  localparam int unsigned CW        = $clog2(N_CELL + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pd_up,
  output logic [N_CELL-1:0] o_sel,
  output logic [CW-1:0]     o_code,
  output logic              o_busy,
  output logic              o_locked,
  output logic              o_err
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TW = $clog2(LOCK_CNT + 1);

  dly_fine_state_t   state_q, state_n;
  logic [CW-1:0]     code_q, code_n;
  logic [SW-1:0]     settle_q, settle_n;
  logic [TW-1:0]     tog_q, tog_n, tog_new;
  logic              dir_q, dir_n;
  logic              pdir_q, pdir_n;
  logic              pval_q, pval_n;
  logic [N_CELL-1:0] sel_q, sel_n;
  logic              busy_q, locked_q, err_q;
  logic              busy_n, locked_n, err_n;
`ifdef DLY_FINE_CTRL_MAJORITY_EN
  logic [1:0]        sidx_q, sidx_n;
  logic [1:0]        samp_q, samp_n;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_n = state_q;
    code_n  = code_q;
    settle_n = settle_q;
    tog_n   = tog_q;
    tog_new = '0;
    dir_n   = dir_q;
    pdir_n  = pdir_q;
    pval_n  = pval_q;
`ifdef DLY_FINE_CTRL_MAJORITY_EN
    sidx_n  = sidx_q;
    samp_n  = samp_q;
`endif

    case (state_q)
      ST_IDLE, ST_LOCKED, ST_ERR: begin
        if (i_start) begin
          code_n   = CW'(N_CELL / 2);
          tog_n    = '0;
          pval_n   = 1'b0;
          settle_n = '0;
          state_n  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          settle_n = '0;
          state_n  = ST_SAMPLE;
        end else begin
          settle_n = settle_q + SW'(1);
        end
      end
      ST_SAMPLE: begin
`ifdef DLY_FINE_CTRL_MAJORITY_EN
        if (sidx_q == 2'd2) begin
          dir_n   = maj3(samp_q[1], samp_q[0], i_pd_up);
          sidx_n  = '0;
          state_n = ST_UPDATE;
        end else begin
          samp_n = {samp_q[0], i_pd_up};
          sidx_n = sidx_q + 2'd1;
        end
`else
        dir_n   = i_pd_up;
        state_n = ST_UPDATE;
`endif
      end
      ST_UPDATE: begin
        if ((dir_q && (code_q == CW'(N_CELL))) || (!dir_q && (code_q == '0))) begin
          state_n = ST_ERR;
        end else begin
          code_n  = dir_q ? (code_q + CW'(1)) : (code_q - CW'(1));
          tog_new = (pval_q && (dir_q != pdir_q)) ? (tog_q + TW'(1)) : '0;
          tog_n   = tog_new;
          pdir_n  = dir_q;
          pval_n  = 1'b1;
          state_n = (tog_new == TW'(LOCK_CNT)) ? ST_LOCKED : ST_SETTLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n   = (state_n == ST_SETTLE) || (state_n == ST_SAMPLE) || (state_n == ST_UPDATE);
    locked_n = (state_n == ST_LOCKED);
    err_n    = (state_n == ST_ERR);
  end

  dly_fine_therm #(.N_CELL(N_CELL)) u_therm (
    .code (code_n),
    .sel  (sel_n)
  );

  // State and registered outputs; status flags track the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      settle_q <= '0;
      tog_q    <= '0;
      dir_q    <= 1'b0;
      pdir_q   <= 1'b0;
      pval_q   <= 1'b0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef DLY_FINE_CTRL_MAJORITY_EN
      sidx_q   <= '0;
      samp_q   <= '0;
`endif
    end else begin
      state_q  <= state_n;
      code_q   <= code_n;
      settle_q <= settle_n;
      tog_q    <= tog_n;
      dir_q    <= dir_n;
      pdir_q   <= pdir_n;
      pval_q   <= pval_n;
      sel_q    <= sel_n;
      busy_q   <= busy_n;
      locked_q <= locked_n;
      err_q    <= err_n;
`ifdef DLY_FINE_CTRL_MAJORITY_EN
      sidx_q   <= sidx_n;
      samp_q   <= samp_n;
`endif
    end
  end

  assign o_sel    = sel_q;
  assign o_code   = code_q;
  assign o_busy   = busy_q;
  assign o_locked = locked_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_dly_fine_ctrl.sv
// Directed self-checking bench for dly_fine_ctrl (N_CELL=16, SETTLE_CYC=4, LOCK_CNT=4).
module tb_dly_fine_ctrl;

`ifdef DLY_FINE_CTRL_MAJORITY_EN
  localparam int PER = 8;
`else
  localparam int PER = 6;
`endif

  logic        clk = 1'b0;
  logic        rst, start, pd;
  logic [15:0] sel;
  logic [4:0]  code;
  logic        busy, locked, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dly_fine_ctrl #(.N_CELL(16), .SETTLE_CYC(4), .LOCK_CNT(4)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_pd_up  (pd),
    .o_sel    (sel),
    .o_code   (code),
    .o_busy   (busy),
    .o_locked (locked),
    .o_err    (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] c, input logic [15:0] s,
                         input logic b, input logic l, input logic e);
    check({tag, ".code"},   32'(code),   32'(c));
    check({tag, ".sel"},    32'(sel),    32'(s));
    check({tag, ".busy"},   32'(busy),   32'(b));
    check({tag, ".locked"}, 32'(locked), 32'(l));
    check({tag, ".err"},    32'(err),    32'(e));
  endtask

  initial begin
    logic [4:0]  dirs;
    logic [4:0]  exp_code [5];
    logic [31:0] therm;

    rst = 1'b1; start = 1'b0; pd = 1'b0;
    tick(2);
    chk_out("reset", 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(3);
    chk_out("idle", 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Climb to the top of the range and overflow.
    pd = 1'b1;
    pulse_start();
    chk_out("start", 5'd8, 16'h00FF, 1'b1, 1'b0, 1'b0);
    tick(PER - 1);
    check("first_hold", 32'(code), 32'd8);
    tick(1);
    check("first_step", 32'(code), 32'd9);
    for (int c = 10; c <= 16; c++) begin
      tick(PER);
      therm = (32'd1 << c) - 32'd1;
      check($sformatf("up_code%0d", c), 32'(code), 32'(c));
      check($sformatf("up_sel%0d", c), 32'(sel), therm);
    end
    tick(PER);
    chk_out("err_top", 5'd16, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    tick(10);
    chk_out("err_hold", 5'd16, 16'hFFFF, 1'b0, 1'b0, 1'b1);

    // Alternating decisions lock at code 9; a start pulse mid-iteration is ignored.
    pd = 1'b1;
    pulse_start();
    chk_out("restart_err", 5'd8, 16'h00FF, 1'b1, 1'b0, 1'b0);
    dirs = 5'b10101;
    exp_code[0] = 5'd9; exp_code[1] = 5'd8; exp_code[2] = 5'd9;
    exp_code[3] = 5'd8; exp_code[4] = 5'd9;
    for (int i = 0; i < 5; i++) begin
      pd = dirs[i];
      if (i == 2) begin
        tick(2);
        pulse_start();
        tick(PER - 3);
      end else begin
        tick(PER);
      end
      check($sformatf("alt_code%0d", i), 32'(code), 32'(exp_code[i]));
      if (i < 4) check($sformatf("alt_unlocked%0d", i), 32'(locked), 32'd0);
    end
    chk_out("lock", 5'd9, 16'h01FF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      pd = ~pd;
      tick(1);
    end
    chk_out("lock_hold", 5'd9, 16'h01FF, 1'b0, 1'b1, 1'b0);
    pulse_start();
    chk_out("restart_lock", 5'd8, 16'h00FF, 1'b1, 1'b0, 1'b0);

    // Reset during SETTLE of the third iteration.
    pd = 1'b1;
    tick(PER);
    check("mid_code9", 32'(code), 32'd9);
    tick(PER);
    check("mid_code10", 32'(code), 32'd10);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk_out("mid_rst", 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(20);
    chk_out("post_rst_idle", 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Start coincident with reset: reset wins.
    rst = 1'b1; start = 1'b1;
    tick(1);
    rst = 1'b0; start = 1'b0;
    chk_out("rst_start", 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick(PER + 2);
    check("rst_start_idle", 32'(code), 32'd0);

`ifdef DLY_FINE_CTRL_MAJORITY_EN
    // Majority of 1,0,1 steps up.
    pd = 1'b1;
    pulse_start();
    tick(4); pd = 1'b1;
    tick(1); pd = 1'b0;
    tick(1); pd = 1'b1;
    tick(1);
    check("maj_hold", 32'(code), 32'd8);
    tick(1);
    check("maj_up", 32'(code), 32'd9);
    // Majority of 0,1,0 steps down.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    pd = 1'b0;
    pulse_start();
    tick(4); pd = 1'b0;
    tick(1); pd = 1'b1;
    tick(1); pd = 1'b0;
    tick(1);
    check("maj_hold2", 32'(code), 32'd8);
    tick(1);
    check("maj_down", 32'(code), 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
